// File: rtl/cram_chain_loader_if.sv
// Beat stream and CRAM chain signals shared between the loader and its environment.
// The slave modport is the loader's view; master is the driving environment.
interface cram_chain_loader_if #(
  parameter int NUM_CHAINS = 4
);
  logic                  s_valid;
  logic                  s_ready;
  logic [NUM_CHAINS-1:0] s_data;
  logic                  cfg_en;
  logic [NUM_CHAINS-1:0] cfg_data;
  logic [NUM_CHAINS-1:0] cfg_q;
  logic                  rb_valid;
  logic [NUM_CHAINS-1:0] rb_data;

  modport master (
    output s_valid, s_data, cfg_q,
    input  s_ready, cfg_en, cfg_data, rb_valid, rb_data
  );

  modport slave (
    input  s_valid, s_data, cfg_q,
    output s_ready, cfg_en, cfg_data, rb_valid, rb_data
  );
endinterface

// File: rtl/cram_chain_loader.sv
// Loads NUM_CHAINS parallel CRAM chains from a valid/ready beat stream with a paced shift strobe.
// Optional CRC-16-CCITT check over the shifted bits is enabled by defining CRAM_CRC_EN.
module cram_chain_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 256,
  parameter int DIV_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [DIV_W-1:0]               clk_div_i,
  cram_chain_loader_if.slave             bus,
`ifdef CRAM_CRC_EN
  input  logic [15:0]                    crc_exp_i,
  output logic [15:0]                    crc_val_o,
`endif
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int CNT_W = $clog2(CHAIN_LEN+1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, ERR} state_e;

  state_e                state_q, state_d;
  logic [NUM_CHAINS-1:0] hold_q, hold_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [NUM_CHAINS-1:0] cfg_data_q, cfg_data_d;
  logic [NUM_CHAINS-1:0] rb_data_q, rb_data_d;

  logic                  strobe;
  logic [CNT_W-1:0]      bit_cnt_inc;
  logic                  last_shift;

`ifdef CRAM_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_exp_q, crc_exp_d;

  // Bits enter MSB-first CRC in chain index order, bit 0 first.
  function automatic logic [15:0] crcUpdate(input logic [15:0] c, input logic [NUM_CHAINS-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
`endif

  assign strobe      = (state_q == SHIFT) && (div_cnt_q == div_q);
  assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
  assign last_shift  = (bit_cnt_inc == CNT_W'(CHAIN_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cfg_data_q <= '0;
      rb_data_q  <= '0;
`ifdef CRAM_CRC_EN
      crc_q      <= 16'hFFFF;
      crc_exp_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cfg_data_q <= cfg_data_d;
      rb_data_q  <= rb_data_d;
`ifdef CRAM_CRC_EN
      crc_q      <= crc_d;
      crc_exp_q  <= crc_exp_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    cfg_data_d = cfg_data_q;
    rb_data_d  = rb_data_q;
`ifdef CRAM_CRC_EN
    crc_d      = crc_q;
    crc_exp_d  = crc_exp_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          div_d     = clk_div_i;
`ifdef CRAM_CRC_EN
          crc_d     = 16'hFFFF;
          crc_exp_d = crc_exp_i;
`endif
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (bus.s_valid) begin
          hold_d    = bus.s_data;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        // A strobe due in the abort cycle still shifts; abort only redirects the next state.
        if (strobe) begin
          bit_cnt_d  = bit_cnt_inc;
          cfg_data_d = hold_q;
          rb_data_d  = bus.cfg_q;
          state_d    = last_shift ? DONE : LOAD;
`ifdef CRAM_CRC_EN
          crc_d      = crcUpdate(crc_q, hold_q);
`endif
          if (last_shift && !abort_i) begin
            done_d = 1'b1;
`ifdef CRAM_CRC_EN
            if (crc_d != crc_exp_q) err_d = 1'b1;
`endif
          end
        end
        if (abort_i) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_ready  = (state_q == LOAD);
  assign bus.cfg_en   = strobe;
  assign bus.cfg_data = strobe ? hold_q : cfg_data_q;
  assign bus.rb_valid = strobe;
  assign bus.rb_data  = strobe ? bus.cfg_q : rb_data_q;
  assign bit_cnt_o    = bit_cnt_q;
  assign busy_o       = (state_q == LOAD) || (state_q == SHIFT);
  assign done_o       = done_q;
  assign err_o        = err_q;
`ifdef CRAM_CRC_EN
  assign crc_val_o    = crc_q;
`endif

endmodule

// File: tb/tb_cram_chain_loader.sv
// Directed self-checking bench for cram_chain_loader (NUM_CHAINS=4, CHAIN_LEN=8).
// The chains are modelled as 8-deep shift registers looped back into cfg_q.
module tb_cram_chain_loader;

  localparam logic [3:0] RB_EXP [8] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] clk_div;
  logic [3:0] bit_cnt;
  logic       busy;
  logic       done;
  logic       err;
  logic       preload = 1'b0;
  logic [7:0] chain [4];
  int         tests = 0;
  int         fails = 0;
  int         lat;
  int         cnt;
`ifdef CRAM_CRC_EN
  logic [15:0] crc_exp;
  logic [15:0] crc_val;
  logic [15:0] crc_good;
`endif

  cram_chain_loader_if #(.NUM_CHAINS(4)) bus ();

  cram_chain_loader #(.NUM_CHAINS(4), .CHAIN_LEN(8), .DIV_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .abort_i   (abort),
    .clk_div_i (clk_div),
    .bus       (bus),
`ifdef CRAM_CRC_EN
    .crc_exp_i (crc_exp),
    .crc_val_o (crc_val),
`endif
    .bit_cnt_o (bit_cnt),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  // Each chain shifts cfg_data in at stage 0 and presents stage 7 as cfg_q.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (preload) chain[i] <= 8'hA5;
      else if (bus.cfg_en) chain[i] <= {chain[i][6:0], bus.cfg_data[i]};
    end
  end

  assign bus.cfg_q = {chain[3][7], chain[2][7], chain[1][7], chain[0][7]};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

`ifdef CRAM_CRC_EN
  function automatic logic [15:0] crcModel();
    logic [15:0] c;
    logic [3:0]  beat;
    c = 16'hFFFF;
    for (int b = 1; b <= 8; b++) begin
      beat = 4'(b);
      for (int i = 0; i < 4; i++) begin
        c = c ^ ({15'd0, beat[i]} << 15);
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic [3:0] div,
                               input logic sv, input logic [3:0] sd);
    start       = st;
    abort       = ab;
    clk_div     = div;
    bus.s_valid = sv;
    bus.s_data  = sd;
  endtask

  // Presents one beat, waits for its handshake and returns cycles from handshake to cfg_en.
  task automatic shiftOne(input logic [3:0] d, output int latency);
    int  w;
    bit  found;
    latency     = -1;
    found       = 1'b0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    w = 0;
    while (!bus.s_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (bus.s_ready) begin
      for (int c = 1; c <= 12 && !found; c++) begin
        @(negedge clk);
        if (bus.cfg_en) begin
          found   = 1'b1;
          latency = c;
        end
      end
    end
  endtask

  // Full 8-beat load at max rate with beats 0x1..0x8 and loopback readback.
  task automatic fullLoad(input string tag, input logic expErr);
    int hs;
    int strobes;
    int lastC;
    hs      = 0;
    strobes = 0;
    lastC   = -1;
    preload = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'h1);
    @(negedge clk);
    preload = 1'b0;
    start   = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.s_data = 4'(hs + 1);
      if (bus.cfg_en) begin
        if (strobes < 8) begin
          checkOutput({tag, "_cfg_data"}, 32'(bus.cfg_data), 32'(strobes + 1));
          checkOutput({tag, "_rb_data"}, 32'(bus.rb_data), 32'(RB_EXP[strobes]));
          checkOutput({tag, "_rb_valid"}, 32'(bus.rb_valid), 32'd1);
          checkOutput({tag, "_bit_cnt_strobe"}, 32'(bit_cnt), 32'(strobes));
          if (lastC >= 0) checkOutput({tag, "_gap"}, 32'(c - lastC), 32'd2);
        end
        lastC = c;
        strobes++;
      end
      if (bus.s_ready) hs++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    checkOutput({tag, "_strobes"}, 32'(strobes), 32'd8);
    checkOutput({tag, "_bit_cnt"}, 32'(bit_cnt), 32'd8);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'h0);
`ifdef CRAM_CRC_EN
    crc_good = crcModel();
    crc_exp  = crc_good;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("rst_cfg_en", 32'(bus.cfg_en), 32'd0);
    checkOutput("rst_cfg_data", 32'(bus.cfg_data), 32'd0);
    checkOutput("rst_rb", 32'({bus.rb_valid, bus.rb_data}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fullLoad("load1", 1'b0);
`ifdef CRAM_CRC_EN
    checkOutput("crc_val", 32'(crc_val), 32'(crc_good));
`endif

    // Divider 3, changed mid-load, then abort after three shifts.
    applyStimulus(1'b1, 1'b0, 4'd3, 1'b0, 4'h0);
    @(negedge clk);
    start   = 1'b0;
    clk_div = 4'd0;
    shiftOne(4'h6, lat);
    checkOutput("div3_lat1", 32'(lat), 32'd4);
    checkOutput("div3_data1", 32'(bus.cfg_data), 32'h6);
    shiftOne(4'h7, lat);
    checkOutput("div3_lat2", 32'(lat), 32'd4);
    shiftOne(4'hC, lat);
    checkOutput("div3_lat3", 32'(lat), 32'd4);
    @(negedge clk);
    bus.s_valid = 1'b0;
    abort       = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_err", 32'(err), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_bit_cnt", 32'(bit_cnt), 32'd3);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_cfg_hold", 32'(bus.cfg_data), 32'hC);
    cnt = 0;
    bus.s_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.cfg_en || bus.s_ready) cnt++;
    end
    checkOutput("abort_quiet", 32'(cnt), 32'd0);

    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'h0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_err", 32'(err), 32'd0);
    checkOutput("restart_bit_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    checkOutput("restart_s_ready", 32'(bus.s_ready), 32'd1);

    // Abort landing on a strobe cycle: that shift still completes.
    shiftOne(4'h9, lat);
    checkOutput("div0_lat", 32'(lat), 32'd1);
    abort       = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_strobe_bit_cnt", 32'(bit_cnt), 32'd1);
    checkOutput("abort_strobe_err", 32'(err), 32'd1);
    checkOutput("abort_strobe_cfg", 32'(bus.cfg_data), 32'h9);

    // Start and abort together from ERR: start wins.
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b0, 4'h0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_wins_busy", 32'(busy), 32'd1);
    checkOutput("start_wins_err", 32'(err), 32'd0);
    shiftOne(4'h3, lat);
    checkOutput("div5_lat", 32'(lat), 32'd6);
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    checkOutput("pre_rst_bit_cnt", 32'(bit_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_bit_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("async_rst_cfg", 32'({bus.cfg_en, bus.cfg_data}), 32'd0);
    checkOutput("async_rst_misc", 32'({bus.s_ready, bus.rb_valid, bus.rb_data, done, err}), 32'd0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    fullLoad("load2", 1'b0);

`ifdef CRAM_CRC_EN
    crc_exp = crc_good ^ 16'h0001;
    fullLoad("crc_bad", 1'b1);
    checkOutput("crc_bad_val", 32'(crc_val), 32'(crc_good));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
